// File: rtl/synfull_inject_queue.sv
// synfull_inject_queue: per-class request FIFOs with zero-latency bypass, round-robin issue, stall/drop overflow, flush drain and saturating stats
module synfull_inject_queue #(
  parameter int NCH = 2,
  parameter int DEPTH = 16,
  parameter int IDw = 32,
  parameter int SIZEw = 4,
  parameter int DSTw = 4,
  parameter int DROP_MODE = 0,
  parameter int CNTw = 32,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int OW = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      req_valid_i,
  input  logic [NCH*IDw-1:0]  req_id_i,
  input  logic [NCH*SIZEw-1:0] req_size_i,
  input  logic [NCH*DSTw-1:0] req_dest_i,
  output logic [NCH-1:0]      req_ready_o,
  input  logic                inj_ready_i,
  output logic                inj_wr_o,
  output logic [IDw-1:0]      inj_id_o,
  output logic [SIZEw-1:0]    inj_size_o,
  output logic [DSTw-1:0]     inj_dest_o,
  output logic [CW-1:0]       inj_class_o,
  input  logic                flush_i,
  output logic                drain_done_o,
  output logic [NCH*OW-1:0]   occupancy_o,
  output logic [CNTw-1:0]     queued_cnt_o,
  output logic [CNTw-1:0]     sent_cnt_o,
  output logic [CNTw-1:0]     drop_cnt_o
);
  localparam int AW = OW - 1;
  localparam int EW = IDw + SIZEw + DSTw;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t r_state;
  logic [EW-1:0] r_mem [NCH][DEPTH];
  logic [AW-1:0] r_wp [NCH];
  logic [AW-1:0] r_rp [NCH];
  logic [OW-1:0] r_occ [NCH];
  logic [CW-1:0] r_rr;
  logic [CW-1:0] w_gnt;
  logic [CNTw-1:0] r_qcnt, r_scnt, r_dcnt;
  logic [NCH-1:0] w_empty, w_full, w_acc, w_cand, w_pop, w_byp, w_push, w_drop;
  logic w_wr;
  logic [EW-1:0] w_head, w_req;

  function automatic logic [CNTw-1:0] sat_add(input logic [CNTw-1:0] a, input int n);
    logic [CNTw+4:0] s;
    s = {5'b0, a} + (CNTw+5)'(n);
    return (|s[CNTw+4:CNTw]) ? '1 : s[CNTw-1:0];
  endfunction

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign w_empty[c] = r_occ[c] == '0;
    assign w_full[c] = r_occ[c] == OW'(DEPTH);
    assign req_ready_o[c] = (r_state == RUN) && (DROP_MODE != 0 || !w_full[c]);
    assign w_acc[c] = req_valid_i[c] && req_ready_o[c];
    assign w_cand[c] = !w_empty[c] || w_acc[c];
    assign w_pop[c] = w_wr && w_gnt == CW'(c) && !w_empty[c];
    assign w_byp[c] = w_wr && w_gnt == CW'(c) && w_empty[c];
    assign w_push[c] = w_acc[c] && !w_byp[c] && !w_full[c];
    assign w_drop[c] = w_acc[c] && !w_byp[c] && w_full[c];
    assign occupancy_o[c*OW +: OW] = r_occ[c];
  end

  always_comb begin
    w_gnt = r_rr;
    for (int i = NCH - 1; i >= 0; i--)
      if (w_cand[(int'(r_rr) + i) % NCH]) w_gnt = CW'((int'(r_rr) + i) % NCH);
  end

  assign w_wr = |w_cand && inj_ready_i;
  assign w_head = r_mem[w_gnt][r_rp[w_gnt]];
  assign w_req = {req_id_i[w_gnt*IDw +: IDw], req_size_i[w_gnt*SIZEw +: SIZEw], req_dest_i[w_gnt*DSTw +: DSTw]};
  assign {inj_id_o, inj_size_o, inj_dest_o} = w_empty[w_gnt] ? w_req : w_head;
  assign inj_wr_o = w_wr;
  assign inj_class_o = w_gnt;
  assign drain_done_o = r_state == DONE;
  assign queued_cnt_o = r_qcnt;
  assign sent_cnt_o = r_scnt;
  assign drop_cnt_o = r_dcnt;

  always_ff @(posedge clk)
    for (int c = 0; c < NCH; c++)
      if (w_push[c]) r_mem[c][r_wp[c]] <= {req_id_i[c*IDw +: IDw], req_size_i[c*SIZEw +: SIZEw], req_dest_i[c*DSTw +: DSTw]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_rr <= '0;
      r_qcnt <= '0;
      r_scnt <= '0;
      r_dcnt <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_wp[c] <= '0;
        r_rp[c] <= '0;
        r_occ[c] <= '0;
      end
    end else begin
      case (r_state)
        RUN: if (flush_i) r_state <= DRAIN;
        DRAIN: if (&w_empty && !w_wr) r_state <= DONE;
        DONE: if (!flush_i) r_state <= RUN;
        default: r_state <= RUN;
      endcase
      if (w_wr) r_rr <= (int'(w_gnt) == NCH - 1) ? '0 : w_gnt + 1'b1;
      r_qcnt <= sat_add(r_qcnt, $countones(w_acc & ~w_drop));
      r_scnt <= sat_add(r_scnt, int'(w_wr));
      r_dcnt <= sat_add(r_dcnt, $countones(w_drop));
      for (int c = 0; c < NCH; c++) begin
        if (w_push[c]) r_wp[c] <= r_wp[c] + 1'b1;
        if (w_pop[c]) r_rp[c] <= r_rp[c] + 1'b1;
        r_occ[c] <= r_occ[c] + OW'(w_push[c]) - OW'(w_pop[c]);
      end
    end
  end
endmodule

// File: tb/tb_synfull_inject_queue.sv
// tb_synfull_inject_queue: directed checks of bypass, stall, round-robin, drop, drain, reset and counter saturation
module tb_synfull_inject_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [2:0] a_valid, a_ready;
  logic [23:0] a_id;
  logic [11:0] a_size, a_dest;
  logic a_inj_ready, a_wr, a_flush, a_done;
  logic [7:0] a_oid;
  logic [3:0] a_osize, a_odest;
  logic [1:0] a_class;
  logic [8:0] a_occ;
  logic [7:0] a_q, a_s, a_d;
  logic [1:0] b_valid, b_ready;
  logic [15:0] b_id;
  logic [7:0] b_size, b_dest;
  logic b_inj_ready, b_wr, b_flush, b_done;
  logic [7:0] b_oid;
  logic [3:0] b_osize, b_odest;
  logic [0:0] b_class;
  logic [5:0] b_occ;
  logic [2:0] b_q, b_s, b_d;
  int checks = 0;
  int failures = 0;

  synfull_inject_queue #(.NCH(3), .DEPTH(4), .IDw(8), .SIZEw(4), .DSTw(4), .DROP_MODE(0), .CNTw(8)) u_a (
    .clk(clk), .reset(reset), .req_valid_i(a_valid), .req_id_i(a_id), .req_size_i(a_size),
    .req_dest_i(a_dest), .req_ready_o(a_ready), .inj_ready_i(a_inj_ready), .inj_wr_o(a_wr),
    .inj_id_o(a_oid), .inj_size_o(a_osize), .inj_dest_o(a_odest), .inj_class_o(a_class),
    .flush_i(a_flush), .drain_done_o(a_done), .occupancy_o(a_occ), .queued_cnt_o(a_q),
    .sent_cnt_o(a_s), .drop_cnt_o(a_d));

  synfull_inject_queue #(.NCH(2), .DEPTH(4), .IDw(8), .SIZEw(4), .DSTw(4), .DROP_MODE(1), .CNTw(3)) u_b (
    .clk(clk), .reset(reset), .req_valid_i(b_valid), .req_id_i(b_id), .req_size_i(b_size),
    .req_dest_i(b_dest), .req_ready_o(b_ready), .inj_ready_i(b_inj_ready), .inj_wr_o(b_wr),
    .inj_id_o(b_oid), .inj_size_o(b_osize), .inj_dest_o(b_odest), .inj_class_o(b_class),
    .flush_i(b_flush), .drain_done_o(b_done), .occupancy_o(b_occ), .queued_cnt_o(b_q),
    .sent_cnt_o(b_s), .drop_cnt_o(b_d));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_valid = '0; a_id = '0; a_size = '0; a_dest = '0; a_inj_ready = 1'b0; a_flush = 1'b0;
    b_valid = '0; b_id = '0; b_size = '0; b_dest = '0; b_inj_ready = 1'b0; b_flush = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    chk("rst_a_occ", a_occ, 0);
    chk("rst_a_cnt", {a_q, a_s, a_d}, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_wr", a_wr, 0);
    chk("rst_a_ready", a_ready, 3'b111);
    chk("rst_b_ready", b_ready, 2'b11);
    chk("rst_b_cnt", {b_q, b_s, b_d}, 0);
    a_inj_ready = 1'b1;
    a_valid = 3'b001;
    a_id[7:0] = 8'hA5; a_size[3:0] = 4'd3; a_dest[3:0] = 4'd2;
    #1;
    chk("byp_wr", a_wr, 1);
    chk("byp_fields", {a_oid, a_osize, a_odest}, {8'hA5, 4'd3, 4'd2});
    chk("byp_class", a_class, 0);
    tick;
    a_valid = '0;
    chk("byp_occ", a_occ, 0);
    chk("byp_queued", a_q, 1);
    chk("byp_sent", a_s, 1);
    a_inj_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      a_valid = 3'b010;
      a_id[15:8] = 8'(8'h10 + k);
      #1;
      chk("stall_ready", a_ready[1], (k < 4));
      chk("stall_wr", a_wr, 0);
      tick;
    end
    a_valid = '0;
    chk("stall_occ", a_occ[5:3], 4);
    chk("stall_queued", a_q, 5);
    chk("stall_ready_full", a_ready, 3'b101);
    a_inj_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_pop_wr", a_wr, 1);
      chk("stall_pop_id", {a_class, a_oid}, {2'd1, 8'(8'h10 + k)});
      tick;
    end
    chk("stall_sent", a_s, 5);
    chk("stall_occ_empty", a_occ, 0);
    reset = 1'b1;
    a_inj_ready = 1'b0;
    tick;
    reset = 1'b0;
    for (int j = 0; j < 2; j++) begin
      a_valid = 3'b111;
      a_id = {8'(8'h60 + j), 8'(8'h50 + j), 8'(8'h40 + j)};
      tick;
    end
    a_valid = '0;
    chk("rr_occ", a_occ, {3'd2, 3'd2, 3'd2});
    chk("rr_queued", a_q, 6);
    a_inj_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_wr", a_wr, 1);
      chk("rr_issue", {a_class, a_oid}, {2'(k % 3), 8'(8'h40 + 16 * (k % 3) + k / 3)});
      tick;
    end
    chk("rr_sent", a_s, 6);
    a_inj_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      a_valid = 3'b100;
      a_id[23:16] = 8'(8'h60 + j);
      tick;
    end
    a_valid = 3'b001;
    a_id[7:0] = 8'h70;
    a_flush = 1'b1;
    a_inj_ready = 1'b1;
    #1;
    chk("flush_edge_ready", a_ready, 3'b111);
    chk("flush_edge_issue", {a_wr, a_class, a_oid}, {1'b1, 2'd0, 8'h70});
    tick;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("drain_ready", a_ready, 3'b000);
      chk("drain_issue", {a_wr, a_class, a_oid}, {1'b1, 2'd2, 8'(8'h60 + j)});
      tick;
    end
    #1;
    chk("drain_idle", {a_wr, a_done}, 2'b00);
    tick;
    chk("drain_done", a_done, 1);
    chk("done_ready", a_ready, 3'b000);
    tick;
    chk("done_hold", a_done, 1);
    a_flush = 1'b0;
    a_valid = '0;
    tick;
    chk("run_done", a_done, 0);
    chk("run_ready", a_ready, 3'b111);
    chk("drain_queued", a_q, 10);
    chk("drain_sent", a_s, 10);
    a_inj_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      a_valid = 3'b001;
      a_id[7:0] = 8'(8'h90 + j);
      tick;
    end
    a_valid = '0;
    chk("mid_occ", a_occ[2:0], 2);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_occ", a_occ, 0);
    chk("mid_rst_cnt", {a_q, a_s, a_d}, 0);
    chk("mid_rst_done", a_done, 0);
    chk("mid_rst_ready", a_ready, 3'b111);
    a_inj_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("mid_rst_no_stale", a_wr, 0);
      tick;
    end
    a_inj_ready = 1'b0;
    b_inj_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      b_valid = 2'b01;
      b_id[7:0] = 8'(8'h80 + k);
      #1;
      chk("drop_ready", b_ready, 2'b11);
      tick;
    end
    b_valid = '0;
    chk("drop_occ", b_occ[2:0], 4);
    chk("drop_cnt", b_d, 3);
    chk("drop_queued", b_q, 4);
    for (int k = 0; k < 5; k++) begin
      b_valid = 2'b01;
      b_id[7:0] = 8'(8'hC0 + k);
      tick;
    end
    b_valid = '0;
    chk("drop_sat", b_d, 7);
    chk("drop_sat_queued", b_q, 4);
    b_inj_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drop_pop", {b_wr, b_class, b_oid}, {1'b1, 1'b0, 8'(8'h80 + k)});
      tick;
    end
    chk("drop_sent", b_s, 4);
    chk("drop_occ_empty", b_occ, 0);
    for (int k = 0; k < 4; k++) begin
      b_valid = 2'b01;
      b_id[7:0] = 8'(8'hE0 + k);
      #1;
      chk("sat_byp", {b_wr, b_oid}, {1'b1, 8'(8'hE0 + k)});
      tick;
    end
    b_valid = '0;
    chk("sat_queued", b_q, 7);
    chk("sat_sent", b_s, 7);
    chk("sat_occ", b_occ, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/synfull_inject_queue.md
# synfull_inject_queue

Parametrised per-endpoint request buffer between a trace or traffic source (SynFull DPI model, trace player) and one `packet_injector`. It supersedes the single-FIFO arrangement used so far with `NCH` independent class queues of bounded depth, a zero-latency bypass, round-robin class arbitration, a selectable stall or drop policy on overflow, a flush/drain handshake, and saturating statistics counters. It is synthesizable and sits in the endpoint wrapper.

## Interface
- `NCH`, 2: number of request classes/channels (1..8).
- `DEPTH`, 16: entries per class FIFO; power of 2, at least 2.
- `IDw`, 32: packet id/data width.
- `SIZEw`, 4: packet size width in flits (`PCK_SIZw`).
- `DSTw`, 4: destination endpoint id width (`NEw`).
- `DROP_MODE`, 0: 0 = stall source when full; 1 = drop and count.
- `CNTw`, 32: statistics counter width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset. This is already decided.
- `req_valid_i` in NCH: per-class request valid.
- `req_id_i` in NCH*IDw: per-class id; class c occupies bits [c*IDw +: IDw]. `req_size_i` and `req_dest_i` use the same packing.
- `req_size_i` in NCH*SIZEw: per-class packet size.
- `req_dest_i` in NCH*DSTw: per-class destination id.
- `req_ready_o` out NCH: per-class acceptance.
- `inj_ready_i` in 1: injector can take a packet this cycle.
- `inj_wr_o` out 1: packet issued to injector.
- `inj_id_o` out IDw, `inj_size_o` out SIZEw, `inj_dest_o` out DSTw: issued packet fields.
- `inj_class_o` out max(1,$clog2(NCH)): class of the issued packet.
- `flush_i` in 1: request drain.
- `drain_done_o` out 1: all queues empty after a flush.
- `occupancy_o` out NCH*($clog2(DEPTH)+1): per-class entry count.
- `queued_cnt_o`, `sent_cnt_o`, `drop_cnt_o` out CNTw each: statistics.

## Operation
- **FSM states** are RUN, DRAIN and DONE.
  - Reset enters RUN.
  - RUN goes to DRAIN when `flush_i`=1.
  - DRAIN goes to DONE when all FIFOs are empty and there is no issue this cycle.
  - DONE goes to RUN when `flush_i`=0.
  - DONE stays in DONE while `flush_i`=1.
- **`req_ready_o[c]`**
  - RUN, `DROP_MODE`=0: `!full[c]`. There is no pop look-ahead.
  - RUN, `DROP_MODE`=1: constant 1.
  - DRAIN and DONE: 0.
- **Accept**: accept[c] = `req_valid_i[c]` & `req_ready_o[c]`.
- **Candidate**: class c is a candidate if its FIFO is non-empty, or if its FIFO is empty and accept[c]=1 (bypass).
- **Arbitration**: round-robin over candidates, starting the search at pointer `rr`.
  - A grant occurs only when `inj_ready_i`=1.
  - After a grant to class g, `rr` becomes (g+1) mod NCH.
  - `rr` resets to 0.
- **Issue**: `inj_wr_o` = any candidate & `inj_ready_i`.
  - Fields come from the granted FIFO head, or from the `req_*_i` inputs when bypassing.
  - Fields are combinational. Their values are don't-care when `inj_wr_o`=0.
- **Queue update**:
  - A granted FIFO head is popped.
  - An accepted request that is not granted via bypass is pushed into its FIFO.
  - Push and pop on the same class in the same cycle keep occupancy unchanged.
  - Per-class order is always FIFO. Bypass is never taken while that class's FIFO holds entries.
- **Drop**: with `DROP_MODE`=1, an accepted request whose FIFO is full and which is not bypassed is discarded. drop[c]=1 for that class.
- **Counters**:
  - `queued_cnt_o` adds popcount(accept & ~drop).
  - `sent_cnt_o` adds `inj_wr_o`.
  - `drop_cnt_o` adds popcount(drop).
  - All three saturate at 2^CNTw-1.
- **`drain_done_o`** = (state==DONE).

## Timing
- **Reset values**: `occupancy_o`=0, all counters 0, `drain_done_o`=0, `inj_wr_o`=0 (all FIFOs empty), `rr`=0.
  - `req_ready_o` = all ones, because RUN state and empty FIFOs.
- **Latency**:
  - Bypass: 0 cycles, request to `inj_wr_o` in the same cycle.
  - Queued entry: issued in the first cycle it wins arbitration with `inj_ready_i`=1.
- **Registers**:
  - FIFO storage, pointers, occupancy, counters, `rr` and state update on `posedge clk`.
  - `occupancy_o` and the counters reflect the previous edge.
- **FIFO pointers** wrap modulo DEPTH. Full is occupancy==DEPTH; empty is occupancy==0.
- **`flush_i` on an accept edge**: accepts in the cycle `flush_i` rises still occur. Ready drops from the next cycle.
- **`reset` mid-operation**: all queued entries are discarded without being issued. The counters clear, and the FSM returns to RUN on the next edge.

## Test plan
- **Bypass**: NCH=2, idle, `inj_ready_i`=1, class 0 valid id=0xA5, size=3, dest=2.
  - Required: `inj_wr_o`=1 in the same cycle with those fields and `inj_class_o`=0.
  - Required: occupancy stays 0; `queued_cnt_o`=1 and `sent_cnt_o`=1 after the edge.
- **Stall**: `DROP_MODE`=0, DEPTH=4, `inj_ready_i`=0, class 1 valid for 6 cycles.
  - Required: 4 accepted, then `req_ready_o[1]`=0, `occupancy_o`=4, `queued_cnt_o`=4.
  - Then `inj_ready_i`=1: ids pop in push order, one per cycle.
- **Round-robin**: NCH=3, preload 2 entries per class with `inj_ready_i`=0, then `inj_ready_i`=1.
  - Required: issue class order 0,1,2,0,1,2 and `sent_cnt_o`=6.
- **Drop**: `DROP_MODE`=1, DEPTH=4, `inj_ready_i`=0, 7 pushes on class 0.
  - Required: `occupancy_o`=4, `drop_cnt_o`=3, `queued_cnt_o`=4.
- **Drain**: 3 queued entries, assert `flush_i` with `inj_ready_i`=1.
  - Required: `req_ready_o`=0 from the next cycle, 3 issues, then `drain_done_o`=1.
  - Required: deasserting `flush_i` returns to RUN and `req_ready_o` is all ones.
- **Reset mid-operation**: assert `reset` with 2 entries queued.
  - Required: after the edge, occupancy 0, counters 0, `inj_wr_o`=0, and no stale entry is ever issued.
